// File: rtl/processing_element.sv
// processing_element: multiply-accumulate cell for a systolic array.
//   Each enabled cycle: acc += InputIn * WeightIn, and both operands are
//   registered and forwarded (activation to the right, weight downward).
// Parameters:
//   WIDTH  - operand width; accumulator is 2*WIDTH bits (wraps on overflow)
//   SIGNED - 0: unsigned operands, 1: two's-complement operands
// Ports:
//   CLK        clock, rising edge
//   ASYNC_RST  asynchronous active-high clear of all registers
//   SYNC_RST   synchronous active-high clear, overrides EN
//   EN         cycle enable for forwarding and accumulation
//   InputIn    activation from left neighbour / array edge
//   WeightIn   weight from top neighbour / array edge
//   InputOut   registered InputIn, to right neighbour
//   WeightOut  registered WeightIn, to bottom neighbour
//   Result     registered accumulator
module processing_element #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic               CLK,
  input  logic               ASYNC_RST,
  input  logic               SYNC_RST,
  input  logic               EN,
  input  logic [WIDTH-1:0]   InputIn,
  input  logic [WIDTH-1:0]   WeightIn,
  output logic [WIDTH-1:0]   InputOut,
  output logic [WIDTH-1:0]   WeightOut,
  output logic [2*WIDTH-1:0] Result
);

  logic [WIDTH-1:0]   in_q;
  logic [WIDTH-1:0]   w_q;
  logic [2*WIDTH-1:0] acc;

  // Extend operands to 2*WIDTH before multiplying. The low 2*WIDTH bits of
  // a product of sign-extended operands equal the two's-complement product,
  // so one unsigned multiplier serves both modes.
  logic               in_ext_bit;
  logic               w_ext_bit;
  logic [2*WIDTH-1:0] in_ext;
  logic [2*WIDTH-1:0] w_ext;
  logic [2*WIDTH-1:0] prod;

  assign in_ext_bit = SIGNED ? InputIn[WIDTH-1]  : 1'b0;
  assign w_ext_bit  = SIGNED ? WeightIn[WIDTH-1] : 1'b0;
  assign in_ext     = {{WIDTH{in_ext_bit}}, InputIn};
  assign w_ext      = {{WIDTH{w_ext_bit}}, WeightIn};
  assign prod       = in_ext * w_ext;

  always_ff @(posedge CLK or posedge ASYNC_RST) begin
    if (ASYNC_RST) begin
      in_q <= '0;
      w_q  <= '0;
      acc  <= '0;
    end else if (SYNC_RST) begin
      in_q <= '0;
      w_q  <= '0;
      acc  <= '0;
    end else if (EN) begin
      in_q <= InputIn;
      w_q  <= WeightIn;
      acc  <= acc + prod;
    end
  end

  assign InputOut  = in_q;
  assign WeightOut = w_q;
  assign Result    = acc;

endmodule

// File: tb/tb_processing_element.sv
module tb_processing_element;

  logic        CLK = 1'b0;
  logic        ASYNC_RST = 1'b1;
  logic        SYNC_RST = 1'b0;
  logic        EN = 1'b0;
  logic [7:0]  InputIn = '0;
  logic [7:0]  WeightIn = '0;
  logic [7:0]  u_in_o, u_w_o, s_in_o, s_w_o;
  logic [15:0] u_res, s_res;

  always #5 CLK = ~CLK;

  processing_element #(.WIDTH(8), .SIGNED(1'b0)) dut_u (
    .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .EN(EN),
    .InputIn(InputIn), .WeightIn(WeightIn),
    .InputOut(u_in_o), .WeightOut(u_w_o), .Result(u_res)
  );

  processing_element #(.WIDTH(8), .SIGNED(1'b1)) dut_s (
    .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .EN(EN),
    .InputIn(InputIn), .WeightIn(WeightIn),
    .InputOut(s_in_o), .WeightOut(s_w_o), .Result(s_res)
  );

  typedef struct {
    bit          sel;   // 0: unsigned instance, 1: signed instance
    logic [7:0]  i;
    logic [7:0]  w;
    logic [15:0] r;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  event chk_now;

  // Monitor: drains expectations at each falling edge, or immediately on
  // chk_now for checks that must happen between clock edges.
  initial begin
    forever begin
      @(negedge CLK or chk_now);
      while (exp_q.size() > 0) begin
        exp_t e;
        logic [7:0]  ai, aw;
        logic [15:0] ar;
        e  = exp_q.pop_front();
        ai = e.sel ? s_in_o : u_in_o;
        aw = e.sel ? s_w_o  : u_w_o;
        ar = e.sel ? s_res  : u_res;
        total++;
        if (ai !== e.i || aw !== e.w || ar !== e.r) begin
          bad++;
          $display("FAIL %s: got in=%0h w=%0h res=%0h, want in=%0h w=%0h res=%0h",
                   e.name, ai, aw, ar, e.i, e.w, e.r);
        end
      end
    end
  end

  task automatic expect_out(input bit sel, input logic [7:0] i, input logic [7:0] w,
                            input logic [15:0] r, input string name);
    exp_t e;
    e.sel = sel; e.i = i; e.w = w; e.r = r; e.name = name;
    exp_q.push_back(e);
  endtask

  // One clock edge with given controls; expectation queued after the edge.
  task automatic step(input logic en, input logic sr, input logic [7:0] i,
                      input logic [7:0] w);
    @(negedge CLK);
    EN = en; SYNC_RST = sr; InputIn = i; WeightIn = w;
    @(posedge CLK);
    #1;
  endtask

  task automatic async_pulse_check(input string name);
    @(posedge CLK);
    #2 ASYNC_RST = 1'b1;
    #1;
    expect_out(0, 8'h00, 8'h00, 16'h0000, {name, "_u"});
    expect_out(1, 8'h00, 8'h00, 16'h0000, {name, "_s"});
    -> chk_now;
    @(negedge CLK);
    EN = 1'b0;
    #1 ASYNC_RST = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, want finish before timeout");
    $fatal(1);
  end

  initial begin
    // Reset state
    #3;
    expect_out(0, 8'h00, 8'h00, 16'h0000, "reset_u");
    expect_out(1, 8'h00, 8'h00, 16'h0000, "reset_s");
    -> chk_now;
    @(negedge CLK);
    #1 ASYNC_RST = 1'b0;

    // First MAC and accumulation
    step(1, 0, 8'd5, 8'd3);  expect_out(0, 8'd5, 8'd3, 16'd15, "first_mac");
    step(1, 0, 8'd7, 8'd2);  expect_out(0, 8'd7, 8'd2, 16'd29, "accum");
    // Enable hold
    step(0, 0, 8'd9, 8'd9);  expect_out(0, 8'd7, 8'd2, 16'd29, "hold1");
    step(0, 0, 8'd9, 8'd9);  expect_out(0, 8'd7, 8'd2, 16'd29, "hold2");
    // Synchronous clear beats EN
    step(1, 1, 8'd4, 8'd4);  expect_out(0, 8'd0, 8'd0, 16'd0,  "sync_clr");
    step(1, 0, 8'd4, 8'd4);  expect_out(0, 8'd4, 8'd4, 16'd16, "after_clr");
    // Async reset between edges with Result nonzero
    async_pulse_check("async_mid");

    // Wrap-around
    step(1, 0, 8'd255, 8'd255); expect_out(0, 8'hFF, 8'hFF, 16'd65025, "wrap1");
    step(1, 0, 8'd255, 8'd255); expect_out(0, 8'hFF, 8'hFF, 16'd64514, "wrap2");
    async_pulse_check("async_wrap");

    // Signed mode: -3*5 = -15, then +2*10 = 5. Unsigned view for contrast:
    // 253*5 = 1265, +20 = 1285.
    step(1, 0, 8'hFD, 8'd5);
    expect_out(1, 8'hFD, 8'h05, 16'hFFF1, "signed1");
    expect_out(0, 8'hFD, 8'h05, 16'd1265, "unsigned_fd");
    step(1, 0, 8'd2, 8'd10);
    expect_out(1, 8'h02, 8'h0A, 16'h0005, "signed2");
    expect_out(0, 8'h02, 8'h0A, 16'd1285, "unsigned_fd2");
    // Signed hold with EN low
    step(0, 0, 8'h80, 8'h80);
    expect_out(1, 8'h02, 8'h0A, 16'h0005, "signed_hold");

    repeat (3) @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations unchecked, want 0", exp_q.size());
    end
    if (total < 12) begin
      bad++;
      $display("FAIL count: only %0d comparisons made, want at least 12", total);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/processing_element.md
# processing_element

Multiply-accumulate cell for the systolic-array core of the deep-learning accelerator. Each enabled cycle it multiplies the incoming activation by the incoming weight, adds the product to a local accumulator, and forwards both operands to its neighbours one cycle later. Activations flow horizontally and weights flow vertically. Instances tile into an N×M grid. Results are read out from each cell's accumulator.

## Interface
- WIDTH, 8: operand width in bits; accumulator is 2*WIDTH.
- SIGNED, 0: 0 = unsigned operands and accumulation; 1 = two's-complement operands, product sign-extended into the accumulator.

- CLK  in  1  single clock; all registers update on the rising edge.
- ASYNC_RST  in  1  asynchronous, active-high reset; clears all registers immediately, independent of CLK.
- SYNC_RST  in  1  synchronous, active-high clear, sampled on the rising CLK edge.
- EN  in  1  cycle enable for operand forwarding and accumulation.
- InputIn  in  WIDTH  activation operand from the left neighbour or the array edge.
- WeightIn  in  WIDTH  weight operand from the top neighbour or the array edge.
- InputOut  out  WIDTH  registered copy of InputIn, to the right neighbour.
- WeightOut  out  WIDTH  registered copy of WeightIn, to the bottom neighbour.
- Result  out  2*WIDTH  accumulator value, registered.

## Operation
- Three registers: in_q (WIDTH), w_q (WIDTH), acc (2*WIDTH). They drive InputOut, WeightOut and Result directly. There is no combinational path from inputs to outputs.
- Rising CLK edge, priority order:
  1. ASYNC_RST high: all registers hold 0, regardless of the clock.
  2. SYNC_RST high: in_q, w_q and acc all load 0. This overrides EN.
  3. EN high: in_q <= InputIn; w_q <= WeightIn; acc <= acc + InputIn*WeightIn.
  4. EN low: all registers hold.
- The product uses the current-cycle InputIn/WeightIn, not the registered copies.
- Arithmetic:
  - The product is full-precision, 2*WIDTH bits.
  - The sum is truncated to 2*WIDTH bits, i.e. it wraps modulo 2^(2*WIDTH).
  - There is no saturation and no overflow flag.
- SIGNED=1: operands are interpreted as two's complement and the product is a 2*WIDTH signed value. Accumulation still wraps.
- EN X/undriven: the RTL need not define the behaviour. Benches must drive EN whenever reset is inactive.

## Timing
- Reset value of every output: InputOut=0, WeightOut=0, Result=0.
- ASYNC_RST takes effect combinationally at its assertion, without waiting for a clock edge. It is released synchronously to the design by the system. The first enabled edge after release accumulates normally.
- Forwarding latency: exactly 1 cycle. InputOut/WeightOut show the values presented at the last enabled edge.
- Accumulation latency: 1 cycle. Result after edge k equals the sum of products for all enabled edges since the last reset.
- SYNC_RST together with EN high: the clear wins, and that cycle's product is discarded.
- ASYNC_RST asserted mid-accumulation: Result goes to 0 immediately. Accumulated state is lost.
- Throughput: one MAC per cycle. There is no handshake or back-pressure beyond EN.

## Test plan
- Reset and first MAC (WIDTH=8, SIGNED=0):
  - Assert ASYNC_RST -> all outputs read 0.
  - Deassert, then EN=1 with InputIn=5, WeightIn=3 for one edge -> InputOut=5, WeightOut=3, Result=15.
- Accumulation: the next edge with EN=1, InputIn=7, WeightIn=2 -> InputOut=7, WeightOut=2, Result=29.
- Enable hold: EN=0 for two edges with InputIn=9, WeightIn=9 -> outputs stay 7/2/29.
- Wrap-around: from reset, two enabled edges with 255×255 -> Result=65025, then 64514, i.e. 130050 mod 65536.
- Synchronous clear:
  - With Result=29, assert SYNC_RST together with EN=1 and operands 4/4 for one edge -> all outputs 0.
  - Deassert SYNC_RST, one edge with 4/4 -> Result=16.
- Asynchronous reset mid-run and signed mode:
  - Assert ASYNC_RST between clock edges while Result≠0 -> outputs 0 before the next edge.
  - SIGNED=1: from reset, operands -3 (0xFD) × 5 -> Result=0xFFF1; then 2×10 -> Result=0x0005.
